// File: rtl/exp_shift_cfg_sequencer.sv
// Defers exponent-shifter reconfiguration to a frame boundary, stalls the input while the shifter drains,
// applies the new fft_size/avg_len, then reports when the block-exponent averager has re-filled.
module exp_shift_cfg_sequencer #(
  parameter int unsigned DRAIN_CYCLES   = 8,
  parameter logic [11:0] RESET_FFT_SIZE = 12'd2048,
  parameter logic [8:0]  RESET_AVG_LEN  = 9'd256
) (
  input  logic        clk,
  input  logic        sync_reset_n,
  input  logic        cfg_valid,
  input  logic [11:0] cfg_fft_size,
  input  logic [8:0]  cfg_avg_len,
  output logic        cfg_ready,
  input  logic        up_tvalid,
  input  logic        up_tlast,
  output logic        up_tready,
  output logic        dn_tvalid,
  input  logic        dn_tready,
  output logic [11:0] fft_size,
  output logic [8:0]  avg_len,
  output logic        settled,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DRAIN,
    S_APPLY,
    S_SETTLE
  } state_t;

  state_t        state_q;
  logic [DW-1:0] drain_cnt_q;
  logic [11:0]   fft_size_q;
  logic [8:0]    avg_len_q;
  logic [11:0]   pend_fft_q;
  logic [8:0]    pend_avg_q;
  logic [8:0]    settle_cnt_q;
  logic          settled_q;
  logic [15:0]   frame_count_q;
  logic [15:0]   frame_count_d;
  logic [8:0]    pend_avg_d;

  logic pass;
  logic acc;
  logic eof;
  logic cfg_acc;
  logic settle_hit;

  assign pass      = (state_q == S_IDLE) || (state_q == S_ARMED) || (state_q == S_SETTLE);
  assign cfg_ready = (state_q == S_IDLE) || (state_q == S_SETTLE);
  assign busy      = (state_q != S_IDLE);
  assign dn_tvalid = up_tvalid & pass;
  assign up_tready = dn_tready & pass;

  assign acc     = up_tvalid & up_tready;
  assign eof     = acc & up_tlast;
  assign cfg_acc = cfg_valid & cfg_ready;

  // Compare one bit wider so avg_len up to 511 never aliases through a 9-bit wrap.
  assign settle_hit    = ({1'b0, settle_cnt_q} + 10'd1) == {1'b0, avg_len_q};
  assign frame_count_d = frame_count_q + 16'd1;
  assign pend_avg_d    = (cfg_avg_len == 9'd0) ? 9'd1 : cfg_avg_len;

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      state_q       <= S_SETTLE;
      drain_cnt_q   <= '0;
      fft_size_q    <= RESET_FFT_SIZE;
      avg_len_q     <= RESET_AVG_LEN;
      pend_fft_q    <= RESET_FFT_SIZE;
      pend_avg_q    <= RESET_AVG_LEN;
      settle_cnt_q  <= '0;
      settled_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      if (eof) frame_count_q <= frame_count_d;
      if (cfg_acc) begin
        pend_fft_q <= cfg_fft_size;
        pend_avg_q <= pend_avg_d;
      end
      case (state_q)
        S_IDLE: begin
          if (cfg_acc) state_q <= S_ARMED;
        end
        S_ARMED: begin
          // Entered only after the accept edge, so an eof in the accept cycle never lands here.
          if (eof) begin
            drain_cnt_q <= DRAIN_LOAD;
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == '0) state_q <= S_APPLY;
          else                   drain_cnt_q <= drain_cnt_q - 1'b1;
        end
        S_APPLY: begin
          fft_size_q   <= pend_fft_q;
          avg_len_q    <= pend_avg_q;
          settle_cnt_q <= '0;
          settled_q    <= 1'b0;
          state_q      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cfg_acc) begin
            state_q <= S_ARMED;
          end else if (eof) begin
            settle_cnt_q <= settle_cnt_q + 9'd1;
            if (settle_hit) begin
              settled_q <= 1'b1;
              state_q   <= S_IDLE;
            end
          end
        end
        default: state_q <= S_SETTLE;
      endcase
    end
  end

  assign fft_size    = fft_size_q;
  assign avg_len     = avg_len_q;
  assign settled     = settled_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_exp_shift_cfg_sequencer.sv
// Directed bench for exp_shift_cfg_sequencer; applied configs are checked against a queue of expected values.
module tb_exp_shift_cfg_sequencer;

  localparam int DRAIN = 8;

  logic        clk;
  logic        sync_reset_n;
  logic        cfg_valid;
  logic [11:0] cfg_fft_size;
  logic [8:0]  cfg_avg_len;
  logic        cfg_ready;
  logic        up_tvalid;
  logic        up_tlast;
  logic        up_tready;
  logic        dn_tvalid;
  logic        dn_tready;
  logic [11:0] fft_size;
  logic [8:0]  avg_len;
  logic        settled;
  logic        busy;
  logic [15:0] frame_count;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_fc   = 0;
  logic [20:0] sb[$];

  exp_shift_cfg_sequencer #(
    .DRAIN_CYCLES  (DRAIN),
    .RESET_FFT_SIZE(12'd2048),
    .RESET_AVG_LEN (9'd256)
  ) dut (
    .clk         (clk),
    .sync_reset_n(sync_reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_fft_size(cfg_fft_size),
    .cfg_avg_len (cfg_avg_len),
    .cfg_ready   (cfg_ready),
    .up_tvalid   (up_tvalid),
    .up_tlast    (up_tlast),
    .up_tready   (up_tready),
    .dn_tvalid   (dn_tvalid),
    .dn_tready   (dn_tready),
    .fft_size    (fft_size),
    .avg_len     (avg_len),
    .settled     (settled),
    .busy        (busy),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Every change of the applied config must match the oldest queued expectation.
  logic [20:0] prev_cfg;
  bit          prev_ok = 1'b0;
  always @(negedge clk) begin
    logic [20:0] want;
    if (prev_ok && ({fft_size, avg_len} !== prev_cfg)) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL cfg_unexpected observed=%0h expected=none", {fft_size, avg_len});
      end
      if (sb.size() != 0) begin
        want = sb.pop_front();
        chk("cfg_apply", 32'({fft_size, avg_len}), 32'(want));
      end
    end
    prev_cfg = {fft_size, avg_len};
    prev_ok  = !$isunknown({fft_size, avg_len});
  end

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(); up_tvalid = 1'b1; up_tlast = 1'b1;
      mid(); chk("frame_rdy", 32'(up_tready), 32'd1);
      exp_fc++;
    end
    cyc(); up_tvalid = 1'b0; up_tlast = 1'b0;
    mid();
  endtask

  task automatic cfg_req(input logic [11:0] f, input logic [8:0] a, input logic [8:0] a_exp, input bit push);
    cyc(); cfg_valid = 1'b1; cfg_fft_size = f; cfg_avg_len = a;
    mid(); chk("cfg_rdy", 32'(cfg_ready), 32'd1);
    if (push) sb.push_back({f, a_exp});
    cyc(); cfg_valid = 1'b0;
    mid(); chk("armed_cfg_rdy", 32'(cfg_ready), 32'd0);
    chk("armed_busy", 32'(busy), 32'd1);
  endtask

  // From ARMED: eof, then hold valid through the stall and measure it.
  task automatic drain_to(input logic [11:0] f, input logic [8:0] a);
    int stall;
    cyc(); up_tvalid = 1'b1; up_tlast = 1'b1;
    mid(); chk("armed_eof_rdy", 32'(up_tready), 32'd1);
    exp_fc++;
    cyc(); up_tlast = 1'b0;
    mid();
    stall = 0;
    while (up_tready === 1'b0 && stall < 40) begin
      chk("stall_dn_vld", 32'(dn_tvalid), 32'd0);
      stall++;
      cyc(); mid();
    end
    chk("stall_len", 32'(stall), 32'(DRAIN + 1));
    chk("new_fft", 32'(fft_size), 32'(f));
    chk("new_avg", 32'(avg_len), 32'(a));
    chk("stall_fc", 32'(frame_count), 32'(exp_fc[15:0]));
    chk("apply_settled", 32'(settled), 32'd0);
    chk("settle_cfg_rdy", 32'(cfg_ready), 32'd1);
    cyc(); up_tvalid = 1'b0;
    mid();
  endtask

  initial begin
    int n_acc;
    int cycles;
    sync_reset_n = 1'b0; cfg_valid = 1'b0; cfg_fft_size = '0; cfg_avg_len = '0;
    up_tvalid = 1'b0; up_tlast = 1'b0; dn_tready = 1'b1;

    // Reset values, then the post-reset fill of 256 frames.
    cyc(); cyc(); mid();
    chk("rst_cfg_rdy", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_settled", 32'(settled), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_fft", 32'(fft_size), 32'd2048);
    chk("rst_avg", 32'(avg_len), 32'd256);
    cyc(); sync_reset_n = 1'b1; dn_tready = 1'b0; up_tvalid = 1'b1;
    mid();
    chk("rst_up_rdy_lo", 32'(up_tready), 32'd0);
    chk("rst_dn_vld", 32'(dn_tvalid), 32'd1);
    cyc(); dn_tready = 1'b1; up_tvalid = 1'b0;
    mid();
    chk("rst_up_rdy_hi", 32'(up_tready), 32'd1);
    chk("rst_dn_vld_lo", 32'(dn_tvalid), 32'd0);
    chk("no_acc_fc", 32'(frame_count), 32'd0);
    frames(255);
    chk("fill_255_settled", 32'(settled), 32'd0);
    frames(1);
    chk("fill_settled", 32'(settled), 32'd1);
    chk("fill_idle", 32'(busy), 32'd0);
    chk("fill_fc", 32'(frame_count), 32'd256);

    // Config accepted mid-frame; drain follows that frame's eof.
    cyc(); up_tvalid = 1'b1; up_tlast = 1'b0;
    cyc(); cfg_valid = 1'b1; cfg_fft_size = 12'd512; cfg_avg_len = 9'd4;
    sb.push_back({12'd512, 9'd4});
    cyc(); cfg_valid = 1'b0;
    mid();
    chk("mid_armed", 32'(cfg_ready), 32'd0);
    chk("mid_pass", 32'(up_tready), 32'd1);
    drain_to(12'd512, 9'd4);
    frames(3);
    chk("mid_3_settled", 32'(settled), 32'd0);
    frames(1);
    chk("mid_settled", 32'(settled), 32'd1);
    chk("mid_idle", 32'(busy), 32'd0);

    // eof in the accept cycle must not start the drain.
    cyc(); up_tvalid = 1'b1; up_tlast = 1'b1;
    cfg_valid = 1'b1; cfg_fft_size = 12'd256; cfg_avg_len = 9'd2;
    sb.push_back({12'd256, 9'd2});
    exp_fc++;
    cyc(); up_tvalid = 1'b0; up_tlast = 1'b0; cfg_valid = 1'b0;
    mid();
    chk("acc_eof_armed", 32'(cfg_ready), 32'd0);
    cyc(); cyc(); mid();
    chk("acc_eof_no_drain", 32'(up_tready), 32'd1);
    drain_to(12'd256, 9'd2);

    // Superseding config during SETTLE, avg_len 0 stored as 1.
    cfg_req(12'd512, 9'd4, 9'd4, 1'b1);
    drain_to(12'd512, 9'd4);
    frames(2);
    cfg_req(12'd1024, 9'd0, 9'd1, 1'b1);
    chk("super_settled_lo", 32'(settled), 32'd0);
    drain_to(12'd1024, 9'd1);
    frames(1);
    chk("super_settled", 32'(settled), 32'd1);
    chk("super_idle", 32'(busy), 32'd0);
    chk("super_fc", 32'(frame_count), 32'(exp_fc[15:0]));

    // Reset during DRAIN discards the pending config.
    cfg_req(12'd2000, 9'd7, 9'd7, 1'b0);
    cyc(); up_tvalid = 1'b1; up_tlast = 1'b1;
    cyc(); up_tlast = 1'b0;
    mid(); chk("drain_stalled", 32'(up_tready), 32'd0);
    cyc(); sync_reset_n = 1'b0;
    sb.push_back({12'd2048, 9'd256});
    mid(); chk("rst_in_drain_stalled", 32'(up_tready), 32'd0);
    cyc();
    cyc(); sync_reset_n = 1'b1; up_tvalid = 1'b0;
    mid();
    chk("drst_pass", 32'(up_tready), 32'd1);
    chk("drst_fft", 32'(fft_size), 32'd2048);
    chk("drst_avg", 32'(avg_len), 32'd256);
    chk("drst_fc", 32'(frame_count), 32'd0);
    chk("drst_settled", 32'(settled), 32'd0);
    chk("drst_busy", 32'(busy), 32'd1);
    exp_fc = 0;

    // Frame counter wrap under random downstream backpressure.
    n_acc = 0;
    cycles = 0;
    while (n_acc < 65537 && cycles < 90000) begin
      cyc(); dn_tready = ($urandom_range(15) != 0); up_tvalid = 1'b1; up_tlast = 1'b1;
      mid(); chk("wrap_gate", 32'(up_tready), 32'(dn_tready));
      if (dn_tready) n_acc++;
      cycles++;
    end
    cyc(); up_tvalid = 1'b0; up_tlast = 1'b0; dn_tready = 1'b1;
    mid();
    chk("wrap_frames", 32'(n_acc), 32'd65537);
    chk("wrap_fc", 32'(frame_count), 32'd1);
    chk("wrap_fft", 32'(fft_size), 32'd2048);
    chk("wrap_avg", 32'(avg_len), 32'd256);
    chk("wrap_settled", 32'(settled), 32'd1);
    chk("wrap_idle", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
